// File: rtl/ariane_pkg.sv
// Shared types for the branch-prediction path.
// bht_update_t: one update to the branch history table (valid, pc, taken).
package ariane_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        taken;
  } bht_update_t;

endpackage

// File: rtl/bht_update_queue.sv
// bht_update_queue
//   Small FIFO that buffers resolved conditional-branch outcomes on their way
//   to the branch history table. The producer is never stalled: an eligible
//   resolution that finds the queue full (with no pop that cycle) is dropped
//   and counted in a saturating counter.
//
// Parameters
//   DEPTH  number of entries (power of two, 2..16)
//   CNT_W  width of the drop counter
//
// Ports
//   clk_i                rising-edge clock
//   rst_ni               synchronous active-low reset
//   flush_i              discard every queued entry (drop count kept)
//   debug_mode_i         ignore resolutions while high
//   resolve_valid_i      resolved control-flow instruction presented
//   resolve_is_branch_i  resolved instruction is a conditional branch
//   resolve_pc_i         PC of the resolved instruction
//   resolve_taken_i      actual branch outcome
//   resolve_ready_o      advisory: queue not full
//   bht_update_o         head entry (valid = queue not empty)
//   update_ready_i       consumer takes bht_update_o this cycle
//   dropped_cnt_o        saturating count of resolutions lost to a full queue
//   empty_o              queue holds no entries
module bht_update_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    debug_mode_i,
  input  logic                    resolve_valid_i,
  input  logic                    resolve_is_branch_i,
  input  logic [63:0]             resolve_pc_i,
  input  logic                    resolve_taken_i,
  output logic                    resolve_ready_o,
  output ariane_pkg::bht_update_t bht_update_o,
  input  logic                    update_ready_i,
  output logic [CNT_W-1:0]        dropped_cnt_o,
  output logic                    empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [63:0]      pc_q    [DEPTH];
  logic             taken_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic [CNT_W-1:0] dropped_cnt_q;

  logic full, empty, eligible, push, pop, drop;

  always_comb begin
    full     = (occ_q == FULL_CNT);
    empty    = (occ_q == '0);
    eligible = resolve_valid_i & resolve_is_branch_i & ~debug_mode_i & ~flush_i;
    pop      = ~empty & update_ready_i;
    // A pop frees the slot in the same cycle, so a full queue can still accept.
    // When empty there is no pop, so the new entry only shows up next cycle.
    push     = eligible & (~full | pop);
    drop     = eligible & full & ~pop;
  end

  // Entry storage carries no reset; validity is tracked by the occupancy.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_q[wr_ptr_q]    <= resolve_pc_i;
      taken_q[wr_ptr_q] <= resolve_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      dropped_cnt_q <= '0;
    end else begin
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
      end
      if (drop && dropped_cnt_q != '1) begin
        dropped_cnt_q <= dropped_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    bht_update_o.valid = ~empty;
    bht_update_o.pc    = pc_q[rd_ptr_q];
    bht_update_o.taken = taken_q[rd_ptr_q];
  end

  assign resolve_ready_o = ~full;
  assign empty_o         = empty;
  assign dropped_cnt_o   = dropped_cnt_q;

endmodule
